// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache for the MEM stage.
// Hits complete in-cycle; misses stall via cache_ready while the line is swapped.
module dcache_ctrl #(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        cache_ready,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int OW = $clog2(WORDS_PER_LINE);
  localparam int IW = $clog2(LINES);
  localparam int TW = 30 - OW - IW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WBACK,
    S_REFILL,
    S_SERVE
  } state_t;

  state_t          r_state;
  logic [OW-1:0]   r_cnt;
  logic [LINES-1:0] r_valid;
  logic [LINES-1:0] r_dirty;
  logic [TW-1:0]   r_tag  [LINES];
  logic [31:0]     r_data [LINES][WORDS_PER_LINE];

  logic [OW-1:0] w_off;
  logic [IW-1:0] w_idx;
  logic [TW-1:0] w_tag;
  logic [TW-1:0] w_vtag;
  logic          w_req;
  logic          w_st;
  logic          w_hit;
  logic          w_idle;
  logic          w_wback;
  logic          w_refill;
  logic          w_serve;
  logic          w_acc;
  logic          w_wr_word;
  logic          w_last;
  logic          w_victim_dirty;
  logic          w_unused;

  assign w_off  = ALUResultM[2 +: OW];
  assign w_idx  = ALUResultM[2+OW +: IW];
  assign w_tag  = ALUResultM[31 -: TW];
  assign w_vtag = r_tag[w_idx];

  assign w_unused = &{1'b0, ALUResultM[1:0]};

  // Load wins when both strobes are set; the store is dropped.
  assign w_req = MemtoRegM | MemWriteM;
  assign w_st  = MemWriteM & ~MemtoRegM;

  assign w_hit          = r_valid[w_idx] && (w_vtag == w_tag);
  assign w_victim_dirty = r_valid[w_idx] & r_dirty[w_idx];

  assign w_idle   = (r_state == S_IDLE);
  assign w_wback  = (r_state == S_WBACK);
  assign w_refill = (r_state == S_REFILL);
  assign w_serve  = (r_state == S_SERVE);

  assign w_acc     = w_req & ((w_idle & w_hit) | w_serve);
  assign w_wr_word = w_acc & w_st;
  assign w_last    = (r_cnt == OW'(WORDS_PER_LINE - 1));

  assign cache_ready = (w_idle & ~(w_req & ~w_hit)) | w_serve;
  assign ReadDataM   = (w_acc & MemtoRegM) ? r_data[w_idx][w_off] : '0;

  assign mem_rd = w_refill;
  assign mem_wr = w_wback;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      w_wback: begin
        mem_addr  = {w_vtag, w_idx, r_cnt, 2'b00};
        mem_wdata = r_data[w_idx][r_cnt];
      end
      w_refill: begin
        mem_addr  = {w_tag, w_idx, r_cnt, 2'b00};
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_req && !w_hit) begin
            r_cnt   <= '0;
            r_state <= w_victim_dirty ? S_WBACK : S_REFILL;
          end else if (w_wr_word) begin
            r_dirty[w_idx] <= 1'b1;
          end
        end
        S_WBACK: begin
          if (mem_ack) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_cnt   <= '0;
              r_state <= S_REFILL;
            end
          end
        end
        S_REFILL: begin
          if (mem_ack) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_cnt          <= '0;
              r_valid[w_idx] <= 1'b1;
              r_dirty[w_idx] <= 1'b0;
              r_tag[w_idx]   <= w_tag;
              r_state        <= S_SERVE;
            end
          end
        end
        S_SERVE: begin
          if (w_wr_word) begin
            r_dirty[w_idx] <= 1'b1;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Data array carries no reset; validity is tracked by r_valid alone.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      if (w_refill && mem_ack) begin
        r_data[w_idx][r_cnt] <= mem_rdata;
      end else if (w_wr_word) begin
        r_data[w_idx][w_off] <= WriteDataM;
      end
    end
  end

endmodule
